// File: rtl/fetch_pkg.sv
// Shared widths, defaults and entry layout for the instruction fetch buffer.
package fetch_pkg;
  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_PC_W  = 64;

  typedef struct packed {
    logic [DEF_PC_W-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// FIFO of {pc, instr} pairs between the PC stage and decode.
// No pass-through when full and no bypass when empty, so both ready/valid sides come straight from state.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned N     = DEF_PC_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                in_pc,
  input  logic [INSTR_W-1:0]          in_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0]                out_pc,
  output logic [INSTR_W-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [N-1:0]       pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Gate the head read so uninitialised storage never reaches decode.
  assign out_pc    = out_valid ? mem_q[rd_ptr_q].pc    : '0;
  assign out_instr = out_valid ? mem_q[rd_ptr_q].instr : '0;

  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr};
        wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
      end
      // Occupancy, not pointer equality, tells full from empty.
      case ({push, pop})
        2'b10:   count_d = CNT_W'(count_q + 1'b1);
        2'b01:   count_d = CNT_W'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the valid gating above hides stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
